// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and constants for the sequence stream producer:
//               FSM state encoding, distribution-mode constants and a helper
//               for sizing the channel index.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package stream_pkg;

  // Producer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Distribution modes (value of cfg_bcast).
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_BCAST = 1'b1;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_stream_producer_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_stream_producer_if
// Description : Bundle of CHANNELS stb/ack output streams sharing one data bus.
//   output_z      : channel c data at [c*WIDTH +: WIDTH]
//   output_z_stb  : per-channel valid (driven by master)
//   output_z_ack  : per-channel accept (driven by slave)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface seq_stream_producer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  logic [CHANNELS*WIDTH-1:0] output_z;
  logic [CHANNELS-1:0]       output_z_stb;
  logic [CHANNELS-1:0]       output_z_ack;

  modport master (output output_z, output output_z_stb, input output_z_ack);
  modport slave  (input  output_z, input  output_z_stb, output output_z_ack);
endinterface
`default_nettype wire

// File: rtl/stream_src_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_src_slot
// Description : Per-channel strobe holder. Raises stb on load, drops it when
//               the channel's ack is seen (or on kill/rst).
//   clk, rst : clock, synchronous active-high reset
//   load     : assert stb from the next cycle
//   kill     : drop stb unconditionally (abort)
//   ack      : channel accept
//   stb      : channel valid
//   acked    : handshake completes at this edge (stb & ack)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module stream_src_slot (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic kill,
  input  logic ack,
  output logic stb,
  output logic acked
);

  assign acked = stb & ack;

  // load wins over the ack-clear so a single-channel round-robin can issue
  // back-to-back words on the same slot.
  always_ff @(posedge clk) begin
    if (rst)        stb <= 1'b0;
    else if (kill)  stb <= 1'b0;
    else if (load)  stb <= 1'b1;
    else if (acked) stb <= 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/seq_stream_producer.sv
`default_nettype none
// ============================================================================
// Module      : seq_stream_producer
// Description : Emits the arithmetic sequence start, start+step, ... (count
//               words per pass) on CHANNELS stb/ack streams, round-robin or
//               broadcast, single-shot or looping until abort.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : run request (ignored while busy) / run termination
//   cfg_*         : run configuration, latched on the accepted start
//   stream        : output stream bundle (master side)
//   busy, done    : run in progress / one-cycle completion pulse
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module seq_stream_producer
  import stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     cfg_start,
  input  logic [WIDTH-1:0]     cfg_step,
  input  logic [COUNT_W-1:0]   cfg_count,
  input  logic                 cfg_loop,
  input  logic                 cfg_bcast,
  seq_stream_producer_if.master stream,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = idx_width(CHANNELS);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_FIN  = FIN;

  logic [1:0]          state;
  logic [WIDTH-1:0]    value;
  logic [WIDTH-1:0]    start_q;
  logic [WIDTH-1:0]    step_q;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  cnt;
  logic                loop_q;
  logic                bcast_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;

  logic [CHANNELS-1:0] stb;
  logic [CHANNELS-1:0] acked;
  logic [CHANNELS-1:0] load;
  logic                accept;
  logic                kill;
  logic                xfer;
  logic                last;

  assign accept   = (state == ST_IDLE) && start;
  assign kill     = (state == ST_SEND) && abort;
  assign idx_next = (idx == IDX_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;

  // Compared one bit wider so cfg_count = 2^COUNT_W-1 cannot wrap.
  assign last = (({1'b0, cnt} + (COUNT_W+1)'(1)) == {1'b0, count_q});

  // Word completion: in broadcast every channel must have dropped its stb or
  // be acking now; in round-robin only the current channel matters.
  always_comb begin
    xfer = 1'b0;
    if ((state == ST_SEND) && !abort) begin
      if (bcast_q == MODE_BCAST) xfer = &(~stb | stream.output_z_ack);
      else                       xfer = acked[idx];
    end
  end

  // Which slots raise stb next cycle: on run start, or after a completed
  // word unless that word ended a non-looping run.
  always_comb begin
    load = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && (cfg_count != '0))
        load[c] = (cfg_bcast == MODE_BCAST) || (IDX_W'(c) == idx);
      else if (xfer && (loop_q || !last))
        load[c] = (bcast_q == MODE_BCAST) || (IDX_W'(c) == idx_next);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    stream_src_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[c]),
      .kill  (kill),
      .ack   (stream.output_z_ack[c]),
      .stb   (stb[c]),
      .acked (acked[c])
    );
  end

  assign stream.output_z     = {CHANNELS{value}};
  assign stream.output_z_stb = stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      value   <= '0;
      start_q <= '0;
      step_q  <= '0;
      count_q <= '0;
      cnt     <= '0;
      loop_q  <= 1'b0;
      bcast_q <= MODE_RR;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            start_q <= cfg_start;
            step_q  <= cfg_step;
            count_q <= cfg_count;
            loop_q  <= cfg_loop;
            bcast_q <= cfg_bcast;
            value   <= cfg_start;
            cnt     <= '0;
            if (cfg_count != '0) begin
              state <= ST_SEND;
              busy  <= 1'b1;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            if (bcast_q == MODE_RR) idx <= idx_next;
            if (last) begin
              if (loop_q) begin
                cnt   <= '0;
                value <= start_q;
              end else begin
                state <= ST_FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt   <= cnt + 1'b1;
              value <= value + step_q;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_producer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stream_producer
// Description : Directed self-checking bench for seq_stream_producer with
//               WIDTH=8, CHANNELS=2. Inputs change and outputs are sampled
//               on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stream_producer;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int COUNT_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   cfg_start;
  logic [WIDTH-1:0]   cfg_step;
  logic [COUNT_W-1:0] cfg_count;
  logic               cfg_loop;
  logic               cfg_bcast;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_stream_producer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  seq_stream_producer #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_start (cfg_start),
    .cfg_step  (cfg_step),
    .cfg_count (cfg_count),
    .cfg_loop  (cfg_loop),
    .cfg_bcast (cfg_bcast),
    .stream    (bus),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected strobe pattern and the value on every lane.
  task automatic word(input string tag, input logic [1:0] s, input logic [7:0] v);
    chk({tag, " stb"},  32'(bus.output_z_stb), 32'(s));
    chk({tag, " data"}, 32'(bus.output_z),     {16'h0, v, v});
  endtask

  // Issue a one-cycle start, then scramble cfg_* to prove they were latched.
  task automatic go(input logic [7:0] st, input logic [7:0] sp, input logic [7:0] cnt,
                    input logic lp, input logic bc);
    cfg_start = st;
    cfg_step  = sp;
    cfg_count = cnt;
    cfg_loop  = lp;
    cfg_bcast = bc;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_start = 8'h5A;
    cfg_step  = 8'h33;
    cfg_count = 8'd7;
    cfg_loop  = ~lp;
    cfg_bcast = ~bc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_step = '0; cfg_count = '0; cfg_loop = 1'b0; cfg_bcast = 1'b0;
    bus.output_z_ack = 2'b00;
    repeat (3) tick();
    chk("reset stb",  32'(bus.output_z_stb), 32'h0);
    chk("reset data", 32'(bus.output_z),     32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    // Round-robin, ack always high: ch0 5,11 / ch1 8,14.
    bus.output_z_ack = 2'b11;
    go(8'd5, 8'd3, 8'd4, 1'b0, 1'b0);
    word("rr w0", 2'b01, 8'd5);
    chk("rr busy", 32'(busy), 32'h1);
    tick(); word("rr w1", 2'b10, 8'd8);
    tick(); word("rr w2", 2'b01, 8'd11);
    tick(); word("rr w3", 2'b10, 8'd14);
    tick();
    chk("rr end stb", 32'(bus.output_z_stb), 32'h0);
    chk("rr done",    32'(done), 32'h1);
    chk("rr busy end", 32'(busy), 32'h0);
    tick();
    chk("rr done pulse", 32'(done), 32'h0);

    // Broadcast, ch1 acks 3 cycles after ch0.
    bus.output_z_ack = 2'b00;
    go(8'd1, 8'd1, 8'd2, 1'b0, 1'b1);
    word("bc w0", 2'b11, 8'd1);
    bus.output_z_ack = 2'b01;
    tick(); word("bc ch0 acked", 2'b10, 8'd1);
    tick(); word("bc wait1", 2'b10, 8'd1);
    tick(); word("bc wait2", 2'b10, 8'd1);
    bus.output_z_ack = 2'b11;
    tick(); word("bc w1", 2'b11, 8'd2);
    tick();
    chk("bc end stb", 32'(bus.output_z_stb), 32'h0);
    chk("bc done",    32'(done), 32'h1);
    tick();

    // Backpressure then wrap through 0xFF.
    bus.output_z_ack = 2'b00;
    go(8'hFE, 8'h01, 8'd4, 1'b0, 1'b0);
    word("bp w0", 2'b01, 8'hFE);
    for (int i = 0; i < 10; i++) begin
      tick(); word("bp hold", 2'b01, 8'hFE);
    end
    bus.output_z_ack = 2'b11;
    tick(); word("wrap w1", 2'b10, 8'hFF);
    tick(); word("wrap w2", 2'b01, 8'h00);
    tick(); word("wrap w3", 2'b10, 8'h01);
    tick();
    chk("wrap done", 32'(done), 32'h1);
    tick();

    // Negative step.
    go(8'd2, 8'hFF, 8'd4, 1'b0, 1'b0);
    word("neg w0", 2'b01, 8'd2);
    tick(); word("neg w1", 2'b10, 8'd1);
    tick(); word("neg w2", 2'b01, 8'd0);
    tick(); word("neg w3", 2'b10, 8'hFF);
    tick();
    chk("neg done", 32'(done), 32'h1);
    tick();

    // Looping run, aborted mid-word with ack high.
    go(8'd10, 8'd1, 8'd3, 1'b1, 1'b0);
    word("loop w0", 2'b01, 8'd10);
    tick(); word("loop w1", 2'b10, 8'd11);
    tick(); word("loop w2", 2'b01, 8'd12);
    tick(); word("loop w3", 2'b10, 8'd10);
    tick(); word("loop w4", 2'b01, 8'd11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort stb",  32'(bus.output_z_stb), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    tick();
    chk("abort no done", 32'(done), 32'h0);
    // Aborted word was not counted, so round-robin resumes on ch0.
    go(8'd7, 8'd1, 8'd1, 1'b0, 1'b0);
    word("post abort", 2'b01, 8'd7);
    tick();
    chk("post abort done", 32'(done), 32'h1);
    tick();

    // Empty run.
    go(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("empty stb",  32'(bus.output_z_stb), 32'h0);
    chk("empty done", 32'(done), 32'h1);
    chk("empty busy", 32'(busy), 32'h0);
    tick();
    chk("empty done pulse", 32'(done), 32'h0);
    chk("empty stb after",  32'(bus.output_z_stb), 32'h0);

    // Start while busy is ignored (idx is now 1).
    bus.output_z_ack = 2'b00;
    go(8'd20, 8'd1, 8'd2, 1'b0, 1'b0);
    word("busy w0", 2'b10, 8'd20);
    cfg_start = 8'd99; cfg_step = 8'd5; cfg_count = 8'd1; cfg_loop = 1'b0; cfg_bcast = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    word("busy hold", 2'b10, 8'd20);
    bus.output_z_ack = 2'b11;
    tick(); word("busy w1", 2'b01, 8'd21);
    tick();
    chk("busy done", 32'(done), 32'h1);
    tick();

    // Reset in the middle of a run.
    bus.output_z_ack = 2'b00;
    go(8'd3, 8'd1, 8'd5, 1'b0, 1'b0);
    word("rst w0", 2'b10, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst stb",  32'(bus.output_z_stb), 32'h0);
    chk("rst data", 32'(bus.output_z),     32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    bus.output_z_ack = 2'b11;
    go(8'd4, 8'd1, 8'd1, 1'b0, 1'b0);
    word("rst idx0", 2'b01, 8'd4);
    tick();
    chk("rst run done", 32'(done), 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
